// File: rtl/mac_burst_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_burst_scheduler_if                                        |
// | Description : Bundle of requester, result and MAC-side signals of the      |
// |               two-requester MAC burst scheduler.                           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface mac_burst_scheduler_if #(
  parameter int DW = 4,
  parameter int OW = 10
);
  // requester 0
  logic          r0_valid;
  logic [DW-1:0] r0_a;
  logic [DW-1:0] r0_b;
  logic          r0_last;
  logic          r0_ready;
  // requester 1
  logic          r1_valid;
  logic [DW-1:0] r1_a;
  logic [DW-1:0] r1_b;
  logic          r1_last;
  logic          r1_ready;
  // burst result
  logic          res_valid;
  logic          res_id;
  logic [OW-1:0] res_data;
  logic          res_err;
  // shared MAC datapath
  logic          mac_in_valid;
  logic [DW-1:0] mac_in1;
  logic [DW-1:0] mac_in2;
  logic          mac_out_valid;
  logic [OW-1:0] mac_out;
  // status
  logic          busy;

  // scheduler side
  modport slave (
    input  r0_valid, r0_a, r0_b, r0_last,
    input  r1_valid, r1_a, r1_b, r1_last,
    input  mac_out_valid, mac_out,
    output r0_ready, r1_ready,
    output res_valid, res_id, res_data, res_err,
    output mac_in_valid, mac_in1, mac_in2,
    output busy
  );

  // environment side: requesters, result consumer and MAC
  modport master (
    output r0_valid, r0_a, r0_b, r0_last,
    output r1_valid, r1_a, r1_b, r1_last,
    output mac_out_valid, mac_out,
    input  r0_ready, r1_ready,
    input  res_valid, res_id, res_data, res_err,
    input  mac_in_valid, mac_in1, mac_in2,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mac_burst_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mac_burst_scheduler                                           |
// | Description : Round-robin arbiter that feeds operand bursts from two       |
// |               requesters into one never-clearing accumulating MAC and      |
// |               returns each burst's dot product as (final acc - base).      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mac_burst_scheduler #(
  parameter int DW      = 4,
  parameter int OW      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_burst_scheduler_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic            grant_q;      // requester owning the current burst
  logic            prio_q;       // 0: r0 favoured on a tie, 1: r1 favoured
  logic            last_q;       // pair in flight is the last of its burst
  logic            err_q;        // current burst has timed out
  logic [CW-1:0]   cnt_q;        // cycles spent waiting for the MAC
  logic [OW-1:0]   base_q;       // accumulator value when the burst started
  logic [OW-1:0]   cap_q;        // accumulator value after the latest pair
  logic [OW-1:0]   acc_seen_q;   // most recent accumulator value reported
  logic            mac_in_valid_q;
  logic [DW-1:0]   mac_in1_q;
  logic [DW-1:0]   mac_in2_q;
  logic            res_valid_q;
  logic            res_id_q;
  logic [OW-1:0]   res_data_q;
  logic            res_err_q;

  logic            open_win;
  logic            sel_valid;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            sel_last;
  logic            timeout_hit;

  // Only the granted requester sees ready, and only while pairs are wanted.
  assign open_win      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.r0_ready  = open_win && !grant_q;
  assign bus.r1_ready  = open_win &&  grant_q;

  assign sel_valid     = grant_q ? bus.r1_valid : bus.r0_valid;
  assign sel_a         = grant_q ? bus.r1_a     : bus.r0_a;
  assign sel_b         = grant_q ? bus.r1_b     : bus.r0_b;
  assign sel_last      = grant_q ? bus.r1_last  : bus.r0_last;

  // The TIMEOUT-th consecutive WAIT cycle without a MAC response aborts.
  assign timeout_hit   = (cnt_q == CW'(TIMEOUT - 1));

  assign bus.mac_in_valid = mac_in_valid_q;
  assign bus.mac_in1      = mac_in1_q;
  assign bus.mac_in2      = mac_in2_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_id       = res_id_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_err      = res_err_q;
  assign bus.busy         = (state_q != S_IDLE);

  // Track the MAC accumulator whenever it reports, regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_seen_q <= '0;
    end else if (bus.mac_out_valid) begin
      acc_seen_q <= bus.mac_out;
    end
  end

  // Burst scheduler FSM; result fields are loaded on the transition into
  // DONE so the strobe is visible while DONE is the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      grant_q        <= 1'b0;
      prio_q         <= 1'b0;
      last_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      base_q         <= '0;
      cap_q          <= '0;
      mac_in_valid_q <= 1'b0;
      mac_in1_q      <= '0;
      mac_in2_q      <= '0;
      res_valid_q    <= 1'b0;
      res_id_q       <= 1'b0;
      res_data_q     <= '0;
      res_err_q      <= 1'b0;
    end else begin
      mac_in_valid_q <= 1'b0;
      mac_in1_q      <= '0;
      mac_in2_q      <= '0;
      res_valid_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.r0_valid || bus.r1_valid) begin
            grant_q <= !(bus.r0_valid && (!prio_q || !bus.r1_valid));
            base_q  <= acc_seen_q;
            // an abort before any MAC response then reports a zero sum
            cap_q   <= acc_seen_q;
            err_q   <= 1'b0;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (sel_valid) begin
            mac_in_valid_q <= 1'b1;
            mac_in1_q      <= sel_a;
            mac_in2_q      <= sel_b;
            last_q         <= sel_last;
            cnt_q          <= '0;
            state_q        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.mac_out_valid) begin
            cap_q <= bus.mac_out;
            if (last_q) begin
              res_valid_q <= 1'b1;
              res_id_q    <= grant_q;
              res_data_q  <= bus.mac_out - base_q;
              res_err_q   <= err_q;
              state_q     <= S_DONE;
            end else begin
              state_q     <= S_ISSUE;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (last_q) begin
              res_valid_q <= 1'b1;
              res_id_q    <= grant_q;
              res_data_q  <= cap_q - base_q;
              res_err_q   <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q     <= S_DRAIN;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DRAIN: begin
          // swallow the rest of the aborted burst without touching the MAC
          if (sel_valid && sel_last) begin
            res_valid_q <= 1'b1;
            res_id_q    <= grant_q;
            res_data_q  <= cap_q - base_q;
            res_err_q   <= err_q;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          err_q   <= 1'b0;
          prio_q  <= ~grant_q;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_burst_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_mac_burst_scheduler                                        |
// | Description : Self-checking bench: queue-driven requesters, a 2-cycle     |
// |               accumulating MAC model and a dot-product/round-robin model. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mac_burst_scheduler;
  localparam int DW      = 4;
  localparam int OW      = 10;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } pair_t;

  typedef struct {
    int id;
    int data;
    int err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_burst_scheduler_if #(.DW(DW), .OW(OW)) bus ();

  mac_burst_scheduler #(.DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    total = 0;
  int    bad   = 0;
  pair_t q0[$];
  pair_t q1[$];
  res_t  exp_q[$];
  res_t  got_q[$];
  int    gap0 = 0, gap1 = 0;
  bit    gaps_on = 0;
  bit    rnd_mode = 0;
  bit    tb_prio = 0;           // 0: r0 favoured next, 1: r1 favoured next
  bit    mac_stall = 0;
  bit    pre_req = 0;
  logic [OW-1:0] pre_val = '0;
  logic          rnd_ov = 1'b0;
  logic [OW-1:0] rnd_out = '0;

  // ---------------- requester drivers ----------------
  always @(negedge clk) begin
    if (rnd_mode) begin
      bus.r0_valid = 1'($urandom); bus.r0_a = DW'($urandom); bus.r0_b = DW'($urandom);
      bus.r0_last  = 1'($urandom);
      rnd_ov = 1'($urandom); rnd_out = OW'($urandom);
    end else if (gap0 > 0) begin
      gap0--;
      bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_last = 1'b0;
    end else if (q0.size() > 0) begin
      bus.r0_valid = 1'b1; bus.r0_a = q0[0].a; bus.r0_b = q0[0].b; bus.r0_last = q0[0].last;
    end else begin
      bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_last = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rnd_mode) begin
      bus.r1_valid = 1'($urandom); bus.r1_a = DW'($urandom); bus.r1_b = DW'($urandom);
      bus.r1_last  = 1'($urandom);
    end else if (gap1 > 0) begin
      gap1--;
      bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_last = 1'b0;
    end else if (q1.size() > 0) begin
      bus.r1_valid = 1'b1; bus.r1_a = q1[0].a; bus.r1_b = q1[0].b; bus.r1_last = q1[0].last;
    end else begin
      bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_last = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && !rnd_mode && bus.r0_valid && bus.r0_ready && q0.size() > 0) begin
      void'(q0.pop_front());
      if (gaps_on) gap0 = $urandom_range(0, 2);
    end
    if (rst_n && !rnd_mode && bus.r1_valid && bus.r1_ready && q1.size() > 0) begin
      void'(q1.pop_front());
      if (gaps_on) gap1 = $urandom_range(0, 2);
    end
  end

  // ---------------- MAC model: out_valid two cycles after in_valid ----------------
  logic          m_p1 = 1'b0;
  logic [OW-1:0] m_prod = '0;
  logic [OW-1:0] m_acc = '0;
  logic          m_ov = 1'b0;
  logic [OW-1:0] m_out = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p1 <= 1'b0; m_acc <= '0; m_ov <= 1'b0; m_out <= '0;
    end else if (pre_req) begin
      m_p1 <= 1'b0; m_acc <= pre_val; m_ov <= 1'b1; m_out <= pre_val;
    end else begin
      m_p1   <= bus.mac_in_valid && !mac_stall;
      m_prod <= OW'(bus.mac_in1) * OW'(bus.mac_in2);
      m_ov   <= m_p1;
      if (m_p1) begin
        m_acc <= m_acc + m_prod;
        m_out <= m_acc + m_prod;
      end
    end
  end

  assign bus.mac_out_valid = rnd_mode ? rnd_ov  : m_ov;
  assign bus.mac_out       = rnd_mode ? rnd_out : m_out;

  // ---------------- monitor ----------------
  int cyc = 0, last_ov_cyc = -10, pulses = 0, viol = 0;
  logic prev_miv = 1'b0;
  always @(negedge clk) begin
    res_t r;
    cyc++;
    if (rst_n && !rnd_mode) begin
      if (bus.mac_in_valid) begin
        pulses++;
        if (prev_miv) viol++;
      end else if (bus.mac_in1 != '0 || bus.mac_in2 != '0) begin
        viol++;
      end
      if (bus.r0_ready && bus.r1_ready) viol++;
      if (bus.res_valid) begin
        r.id = int'(bus.res_id); r.data = int'(bus.res_data); r.err = int'(bus.res_err);
        got_q.push_back(r);
        if (!bus.res_err && last_ov_cyc != cyc - 1) viol++;
      end
      if (bus.mac_out_valid) last_ov_cyc = cyc;
    end
    prev_miv = bus.mac_in_valid;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input int id, input int a, input int b, input bit last);
    pair_t p;
    p.a = a[DW-1:0]; p.b = b[DW-1:0]; p.last = last;
    if (id == 0) q0.push_back(p); else q1.push_back(p);
  endtask

  // served burst's requester loses priority to the other one
  task automatic expect_res(input int id, input int data, input int err);
    res_t r;
    r.id = id; r.data = data % (1 << OW); r.err = err;
    exp_q.push_back(r);
    tb_prio = (id == 0);
  endtask

  task automatic rand_burst(input int id, output int sum);
    int len, a, b;
    len = $urandom_range(1, 4);
    sum = 0;
    for (int i = 0; i < len; i++) begin
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      send(id, a, b, i == len - 1);
      sum += a * b;
    end
  endtask

  task automatic preload(input int v);
    pre_val = OW'(v); pre_req = 1'b1;
    sync();
    pre_req = 1'b0;
    sync();
  endtask

  task automatic collect(input int limit);
    res_t e, g;
    int n = 0;
    while (got_q.size() < exp_q.size() && n < limit) begin
      @(negedge clk); n++;
    end
    chk("res_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      chk("res_id", g.id, e.id);
      chk("res_data", g.data, e.data);
      chk("res_err", g.err, e.err);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete(); got_q.delete();
    gap0 = 0; gap1 = 0; tb_prio = 0; mac_stall = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, p0, s0, s1, sid;

    // 1: reset held with random inputs
    rnd_mode = 1'b1;
    rst_n = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_mac_in_valid", bus.mac_in_valid, 0);
    chk("rst_mac_in1", bus.mac_in1, 0);
    chk("rst_mac_in2", bus.mac_in2, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_r0_ready", bus.r0_ready, 0);
    chk("rst_r1_ready", bus.r1_ready, 0);
    rnd_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    chk("idle_busy", bus.busy, 0);

    // 2: single r0 burst, 1*2+2*3+3*4 = 20
    p0 = pulses;
    send(0, 1, 2, 0); send(0, 2, 3, 0); send(0, 3, 4, 1);
    expect_res(0, 20, 0);
    collect(200);
    chk("t2_pulses", pulses - p0, 3);

    // 3: both valid after reset, r0 favoured first
    do_reset();
    send(0, 2, 3, 0); send(0, 1, 4, 1);
    send(1, 5, 5, 1);
    expect_res(0, 10, 0);
    expect_res(1, 25, 0);
    collect(300);
    // move the pointer to r1, then contend again
    sync();
    send(0, 1, 1, 1);
    expect_res(0, 1, 0);
    collect(200);
    sync();
    send(0, 6, 2, 1);
    send(1, 5, 5, 1);
    expect_res(1, 25, 0);
    expect_res(0, 12, 0);
    collect(300);

    // 4: accumulator preloaded to 1000, r1 burst of 450 wraps
    sync();
    preload(1000);
    send(1, 15, 15, 0); send(1, 15, 15, 1);
    expect_res(1, 450, 0);
    collect(200);

    // 5: MAC stalls after the first pair -> timeout, drain, err
    sync();
    send(0, 3, 5, 0); send(0, 2, 2, 0); send(0, 1, 1, 1);
    expect_res(0, 15, 1);
    n = 0;
    while (bus.mac_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("t5_first_out", bus.mac_out_valid, 1);
    mac_stall = 1'b1;
    collect(TIMEOUT + 200);
    mac_stall = 1'b0;
    sync();
    send(1, 4, 4, 1);
    expect_res(1, 16, 0);
    collect(200);

    // 6: reset pulsed while waiting on the MAC
    sync();
    send(1, 3, 3, 0); send(1, 4, 4, 1);
    n = 0;
    while (bus.mac_in_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("t6_issued", bus.mac_in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_mac_in_valid", bus.mac_in_valid, 0);
    chk("t6_res_valid", bus.res_valid, 0);
    chk("t6_r1_ready", bus.r1_ready, 0);
    q0.delete(); q1.delete(); exp_q.delete(); got_q.delete();
    tb_prio = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sync();
    chk("t6_no_res", got_q.size(), 0);
    send(0, 2, 2, 1);
    expect_res(0, 4, 0);
    collect(200);

    // random bursts, bubbles, contention and accumulator preloads
    gaps_on = 1'b1;
    for (int it = 0; it < 24; it++) begin
      sync();
      gap0 = 0; gap1 = 0;
      if ($urandom_range(0, 3) == 0) preload($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) begin
        rand_burst(0, s0);
        rand_burst(1, s1);
        if (tb_prio == 0) begin
          expect_res(0, s0, 0); expect_res(1, s1, 0);
        end else begin
          expect_res(1, s1, 0); expect_res(0, s0, 0);
        end
      end else begin
        sid = $urandom_range(0, 1);
        rand_burst(sid, s0);
        expect_res(sid, s0, 0);
      end
      collect(400);
    end

    chk("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
